instr_encoder: RTL

Sequential RV32I instruction encoder for the subset handled by the core's immediate generator: `lw`, `sw`, `addi` and `beq`. It accepts decoded fields (operation, registers, signed immediate) over a valid/ready handshake and range-checks the immediate. It packs legal requests into 32-bit instruction words and emits them through a 2-entry output FIFO, each tagged with a running byte address. It sits between the test-program generator and instruction-memory preload, and is the inverse of the immediate extraction path.

---
 rtl/isa_pkg.sv | 73 +++++++
 rtl/instr_encoder_fifo2.sv | 56 +++++
 rtl/instr_encoder.sv | 75 +++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared RV32I encoding constants, request/FIFO payload types and the
// combinational encode + immediate range-check function.
package isa_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;

   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

   localparam logic [F3_W-1:0] F3_LW   = 3'b010;
   localparam logic [F3_W-1:0] F3_SW   = 3'b010;
   localparam logic [F3_W-1:0] F3_ADDI = 3'b000;
   localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;

   typedef enum logic [1:0] {
      OP_LW   = 2'b00,
      OP_SW   = 2'b01,
      OP_ADDI = 2'b10,
      OP_BEQ  = 2'b11
   } op_e;

   typedef struct packed {
      logic            legal;
      logic [XLEN-1:0] instr;
   } enc_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] addr;
   } fifo_entry_t;

   localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

   // Pack one request; legal is low when the immediate cannot be represented.
   function automatic enc_t encode(input op_e              op,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs1,
                                   input logic [REG_W-1:0] rs2,
                                   input logic [XLEN-1:0]  imm);
      enc_t r;
      logic fits_is;
      logic fits_b;
      fits_is = (imm[31:11] == '0) || (imm[31:11] == '1);
      fits_b  = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
      r.legal = 1'b0;
      r.instr = '0;
      case (op)
         OP_LW: begin
            r.legal = fits_is;
            r.instr = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
         end
         OP_SW: begin
            r.legal = fits_is;
            r.instr = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
         end
         OP_ADDI: begin
            r.legal = fits_is;
            r.instr = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
         end
         OP_BEQ: begin
            r.legal = fits_b;
            r.instr = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo2.sv
// Two-entry FIFO with a registered head so the output holds its last
// value once drained; full/empty are registered flags.
module fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_push   = push && !full;
      do_pop    = pop && !empty;
      count_nxt = count;
      if (do_push && !do_pop) count_nxt = count + 2'd1;
      else if (do_pop && !do_push) count_nxt = count - 2'd1;
   end

   // Pushing while popping is only possible with one entry: the new item becomes head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == 2'd2);
         empty <= (count_nxt == 2'd0);
         if (do_push && do_pop) begin
            head <= din;
         end else if (do_push) begin
            if (empty) head <= din;
            else       tail <= din;
         end else if (do_pop && full) begin
            head <= tail;
         end
      end
   end

   assign dout = head;

endmodule

// File: rtl/instr_encoder.sv
// Encodes lw/sw/addi/beq requests into RV32I words, tags them with a running
// byte address and queues them; rejected requests pulse err and bump err_count.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [7:0]  err_count
);

   import isa_pkg::*;

   localparam int unsigned CNT_W = 8;

   enc_t        enc;
   fifo_entry_t push_data;
   fifo_entry_t head;
   logic        accept;
   logic        push;
   logic        full;
   logic        empty;
   logic [XLEN-1:0] pc;

   always_comb begin
      accept         = in_valid && in_ready;
      enc            = encode(op_e'(in_op), in_rd, in_rs1, in_rs2, in_imm);
      push           = accept && enc.legal;
      push_data      = '0;
      push_data.instr = enc.instr;
      push_data.addr  = pc;
   end

   // Address advances only on enqueue; rejected requests leave it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= BASE_ADDR;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         err <= accept && !enc.legal;
         if (push) pc <= pc + XLEN'(4);
         if (accept && !enc.legal && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + CNT_W'(1);
      end
   end

   fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (out_ready),
      .din   (push_data),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_instr = head.instr;
   assign out_addr  = head.addr;

endmodule
